// File: rtl/fx3_transfer_ctrl_pkg.sv
// fx3_transfer_pkg: shared state encoding and default sizing for the FX3 transfer controller
package fx3_transfer_pkg;
   localparam int DEF_BURST_WORDS = 8192;
   localparam int DEF_DATA_W      = 16;
   localparam int DEF_CNT_W       = 14;
   localparam int PIPE_LAT        = 2;
   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, HOLDOFF} state_t;
endpackage

// File: rtl/fx3_transfer_ctrl_if.sv
// fx3_transfer_ctrl_if: buffer read port, GPIF write port and status of the FX3 transfer controller
interface fx3_transfer_ctrl_if
   import fx3_transfer_pkg::*;
#(
   parameter int DW = DEF_DATA_W
);
   logic          collect_data;
   logic          fx3_ready;
   logic          data_available;
   logic [DW-1:0] buffer_data;
   logic          read_request;
   logic [DW-1:0] fx3_data;
   logic          fx3_data_valid;
   logic          fx3_packet_end;
   logic          buffer_underrun;
   logic          protocol_error;
   logic [15:0]   burst_count;
   modport slave (
      input  collect_data, fx3_ready, data_available, buffer_data,
      output read_request, fx3_data, fx3_data_valid, fx3_packet_end,
             buffer_underrun, protocol_error, burst_count
   );
   modport master (
      output collect_data, fx3_ready, data_available, buffer_data,
      input  read_request, fx3_data, fx3_data_valid, fx3_packet_end,
             buffer_underrun, protocol_error, burst_count
   );
endinterface

// File: rtl/fx3_read_pipe.sv
// fx3_read_pipe: two-stage valid/last pipeline from buffer read strobe to GPIF write registers
// Build macro TEST_PATTERN_EN: data output becomes a free-running word counter instead of buffer data.
module fx3_read_pipe
   import fx3_transfer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic              i_last,
   input  logic              i_full,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_s1_full,
   output logic              o_valid,
   output logic              o_last,
   output logic [DATA_W-1:0] o_data
);
   logic              r_v1, r_l1, r_f1;
   logic              r_valid, r_last;
   logic [DATA_W-1:0] r_data;

   // stage 1 tags the word the buffer is fetching during this cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_v1 <= 1'b0;
         r_l1 <= 1'b0;
         r_f1 <= 1'b0;
      end else begin
         r_v1 <= i_valid;
         r_l1 <= i_last;
         r_f1 <= i_full;
      end
   end

   // stage 2 registers the GPIF write strobe and end-of-packet marker
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_valid <= r_v1;
         r_last  <= r_v1 & r_l1;
      end
   end

`ifdef TEST_PATTERN_EN
   logic [DATA_W-1:0] r_pat;

   // counter replaces buffer data and advances once per delivered word, across bursts
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data <= '0;
         r_pat  <= '0;
      end else if (r_v1) begin
         r_data <= r_pat;
         r_pat  <= r_pat + DATA_W'(1);
      end
   end
`else
   // buffer q is valid the cycle after the read strobe and is captured untouched
   always_ff @(posedge i_clk) begin
      if (i_rst) r_data <= '0;
      else       r_data <= i_data;
   end
`endif

   assign o_s1_full = r_f1;
   assign o_valid   = r_valid;
   assign o_last    = r_last;
   assign o_data    = r_data;
endmodule

// File: rtl/fx3_transfer_ctrl.sv
// fx3_transfer_ctrl: reads one full ping-pong buffer per burst and streams it to the FX3 GPIF
// Build macro TEST_PATTERN_EN (handled in fx3_read_pipe) swaps buffer data for a counter.
module fx3_transfer_ctrl
   import fx3_transfer_pkg::*;
#(
   parameter int BURST_WORDS = DEF_BURST_WORDS,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int CNT_W       = DEF_CNT_W
) (
   input logic                i_clk,
   input logic                i_rst,
   fx3_transfer_ctrl_if.slave bus
);
   state_t           r_state;
   logic [CNT_W-1:0] r_word_cnt;
   logic [1:0]       r_flush_cnt;
   logic             r_read_request;
   logic             r_collect_d;
   logic             r_underrun;
   logic             r_protocol;
   logic [15:0]      r_burst_count;
   logic             w_start, w_last_word, w_pipe_last, w_pipe_full, w_s1_full;

   assign w_start     = bus.collect_data & bus.data_available & bus.fx3_ready;
   assign w_last_word = r_word_cnt == CNT_W'(BURST_WORDS - 1);
   assign w_pipe_last = r_read_request & (w_last_word | ~bus.data_available);
   assign w_pipe_full = r_read_request & w_last_word;

   // burst sequencing: wait for data, stream one buffer, drain the pipe, then wait for the buffer to swap
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= IDLE;
         r_word_cnt     <= '0;
         r_flush_cnt    <= '0;
         r_read_request <= 1'b0;
         r_collect_d    <= 1'b0;
         r_underrun     <= 1'b0;
         r_protocol     <= 1'b0;
      end else begin
         r_collect_d <= bus.collect_data;
         case (r_state)
            IDLE: begin
               if (bus.collect_data & ~r_collect_d) begin
                  r_underrun <= 1'b0;
                  r_protocol <= 1'b0;
               end
               if (w_start) begin
                  r_state        <= STREAM;
                  r_read_request <= 1'b1;
                  r_word_cnt     <= '0;
               end
            end
            STREAM: begin
               r_word_cnt <= r_word_cnt + CNT_W'(1);
               if (~bus.fx3_ready) r_protocol <= 1'b1;
               if (w_last_word | ~bus.data_available) begin
                  r_state        <= FLUSH;
                  r_read_request <= 1'b0;
                  r_flush_cnt    <= '0;
                  if (~w_last_word) r_underrun <= 1'b1;
               end
            end
            FLUSH: begin
               r_flush_cnt <= r_flush_cnt + 2'd1;
               if (r_flush_cnt == 2'(PIPE_LAT - 1)) r_state <= HOLDOFF;
            end
            default: begin
               if (~bus.data_available) r_state <= IDLE;
            end
         endcase
      end
   end

   // completed full bursts, counted as the last word's strobe is registered
   always_ff @(posedge i_clk) begin
      if (i_rst)          r_burst_count <= '0;
      else if (w_s1_full) r_burst_count <= r_burst_count + 16'd1;
   end

   fx3_read_pipe #(.DATA_W(DATA_W)) u_pipe (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   (r_read_request),
      .i_last    (w_pipe_last),
      .i_full    (w_pipe_full),
      .i_data    (bus.buffer_data),
      .o_s1_full (w_s1_full),
      .o_valid   (bus.fx3_data_valid),
      .o_last    (bus.fx3_packet_end),
      .o_data    (bus.fx3_data)
   );

   assign bus.read_request    = r_read_request;
   assign bus.buffer_underrun = r_underrun;
   assign bus.protocol_error  = r_protocol;
   assign bus.burst_count     = r_burst_count;
endmodule

// File: tb/tb_fx3_transfer_ctrl.sv
// tb_fx3_transfer_ctrl: directed bursts against a word-queue model of the GPIF stream
module tb_fx3_transfer_ctrl;
   import fx3_transfer_pkg::*;
   localparam int N = DEF_BURST_WORDS;
`ifdef TEST_PATTERN_EN
   localparam bit PAT = 1'b1;
`else
   localparam bit PAT = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] d;
      logic        last;
      logic        full;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fx3_transfer_ctrl_if ifc ();
   fx3_transfer_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(ifc.slave));

   int          n_chk = 0;
   int          n_err = 0;
   exp_t        exp_q[$];
   logic [15:0] buf_base = 16'h0;
   int unsigned buf_start = 0;
   int unsigned rd_total = 0;
   int          run = 0, last_run = 0, rises = 0;
   logic        rq_q = 1'b0;
   logic [15:0] last_word;

   // buffer: q is valid the cycle after each read strobe
   always @(posedge clk) begin
      if (ifc.read_request) begin
         ifc.buffer_data <= buf_base + 16'(rd_total - buf_start);
         rd_total <= rd_total + 1;
      end
   end

   // read strobe run lengths and burst starts
   always @(posedge clk) begin
      rq_q <= ifc.read_request;
      if (ifc.read_request) run <= run + 1;
      else if (run != 0) begin
         last_run <= run;
         run <= 0;
      end
      if (ifc.read_request && !rq_q) rises <= rises + 1;
   end

   // model: each read strobe becomes the next queued word two cycles later
   logic        m_h1 = 1'b0, m_valid = 1'b0, m_pe = 1'b0, m_oob = 1'b0;
   logic [15:0] m_data = 16'h0, m_pat = 16'h0, m_bursts = 16'h0;
   int          m_idx = 0;
   always @(posedge clk) begin
      exp_t e;
      if (rst) begin
         m_h1 = 1'b0; m_valid = 1'b0; m_pe = 1'b0; m_oob = 1'b0;
         m_idx = 0; m_pat = 16'h0; m_bursts = 16'h0;
      end else begin
         m_valid = m_h1;
         m_h1 = ifc.read_request;
         m_pe = 1'b0;
         m_oob = 1'b0;
         if (m_valid) begin
            if (m_idx < exp_q.size()) begin
               e = exp_q[m_idx];
               m_idx++;
               m_data = PAT ? m_pat : e.d;
               m_pe = e.last;
               if (e.last && e.full) m_bursts++;
            end else m_oob = 1'b1;
            m_pat++;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp();
      chk("valid", {31'b0, ifc.fx3_data_valid}, {31'b0, m_valid});
      chk("pkt_end", {31'b0, ifc.fx3_packet_end}, {31'b0, m_pe});
      chk("bursts", {16'b0, ifc.burst_count}, {16'b0, m_bursts});
      chk("word_expected", {31'b0, m_oob}, 32'd0);
      if (m_valid) chk("data", {16'b0, ifc.fx3_data}, {16'b0, m_data});
   endtask

   task automatic tick();
      @(negedge clk);
      cmp();
      @(posedge clk);
      #1;
   endtask

   task automatic push_burst(input logic [15:0] base, input int len, input logic full);
      for (int i = 0; i < len; i++) exp_q.push_back('{16'(base + 16'(i)), i == len - 1, full});
      buf_base = base;
      buf_start = rd_total;
   endtask

   task automatic wait_end(input int budget);
      int k = 0;
      while (!ifc.fx3_packet_end && k < budget) begin
         tick();
         k++;
      end
      chk("pkt_end_seen", {31'b0, ifc.fx3_packet_end}, 32'd1);
      last_word = ifc.fx3_data;
      tick();
   endtask

   task automatic wait_rq(input int budget);
      int k = 0;
      while (!ifc.read_request && k < budget) begin
         tick();
         k++;
      end
      chk("rq_seen", {31'b0, ifc.read_request}, 32'd1);
   endtask

   initial begin
      ifc.collect_data = 1'b0;
      ifc.fx3_ready = 1'b0;
      ifc.data_available = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rq", {31'b0, ifc.read_request}, 32'd0);
      chk("rst_valid", {31'b0, ifc.fx3_data_valid}, 32'd0);
      chk("rst_pe", {31'b0, ifc.fx3_packet_end}, 32'd0);
      chk("rst_underrun", {31'b0, ifc.buffer_underrun}, 32'd0);
      chk("rst_proto", {31'b0, ifc.protocol_error}, 32'd0);
      chk("rst_bursts", {16'b0, ifc.burst_count}, 32'd0);
      rst = 1'b0;
      tick();
      tick();

      push_burst(16'h0000, N, 1'b1);
      ifc.collect_data = 1'b1;
      ifc.fx3_ready = 1'b1;
      ifc.data_available = 1'b1;
      chk("rq_not_yet", {31'b0, ifc.read_request}, 32'd0);
      tick();
      chk("rq_start", {31'b0, ifc.read_request}, 32'd1);
      wait_end(N + 20);
      chk("b1_run", last_run, N);
      chk("b1_bursts", {16'b0, ifc.burst_count}, 32'd1);
      chk("b1_last_word", {16'b0, last_word}, 32'd8191);
      chk("b1_model_idx", m_idx, exp_q.size());

      repeat (50) tick();
      chk("holdoff_rises", rises, 1);
      chk("holdoff_rq", {31'b0, ifc.read_request}, 32'd0);
      ifc.data_available = 1'b0;
      tick();
      tick();
      push_burst(16'hA000, N, 1'b1);
      ifc.data_available = 1'b1;
      wait_end(N + 20);
      chk("b2_run", last_run, N);
      chk("b2_rises", rises, 2);
      chk("b2_bursts", {16'b0, ifc.burst_count}, 32'd2);
      chk("b2_last_word", {16'b0, last_word}, PAT ? 32'h3FFF : 32'hBFFF);

      ifc.data_available = 1'b0;
      tick();
      tick();
      push_burst(16'h1234, 101, 1'b0);
      ifc.data_available = 1'b1;
      wait_rq(20);
      repeat (100) tick();
      chk("rq_word100", {31'b0, ifc.read_request}, 32'd1);
      ifc.data_available = 1'b0;
      wait_end(50);
      chk("ur_flag", {31'b0, ifc.buffer_underrun}, 32'd1);
      chk("ur_run", last_run, 101);
      chk("ur_bursts", {16'b0, ifc.burst_count}, 32'd2);
      chk("ur_proto", {31'b0, ifc.protocol_error}, 32'd0);
      chk("ur_last_word", {16'b0, last_word}, PAT ? 32'h4064 : 32'h1298);
      repeat (3) tick();
      chk("ur_rq_idle", {31'b0, ifc.read_request}, 32'd0);
      ifc.collect_data = 1'b0;
      tick();
      tick();
      ifc.collect_data = 1'b1;
      tick();
      tick();
      chk("ur_cleared", {31'b0, ifc.buffer_underrun}, 32'd0);

      push_burst(16'h5000, N, 1'b1);
      ifc.data_available = 1'b1;
      wait_rq(20);
      repeat (3000) tick();
      ifc.fx3_ready = 1'b0;
      repeat (10) tick();
      ifc.fx3_ready = 1'b1;
      wait_end(N + 20);
      chk("pe_flag", {31'b0, ifc.protocol_error}, 32'd1);
      chk("pe_underrun", {31'b0, ifc.buffer_underrun}, 32'd0);
      chk("pe_run", last_run, N);
      chk("pe_bursts", {16'b0, ifc.burst_count}, 32'd3);
      chk("pe_last_word", {16'b0, last_word}, PAT ? 32'h6064 : 32'h6FFF);
      chk("pe_model_idx", m_idx, exp_q.size());

      ifc.data_available = 1'b0;
      repeat (3) tick();
      push_burst(16'h7000, N, 1'b1);
      ifc.data_available = 1'b1;
      wait_rq(20);
      repeat (50) tick();
      rst = 1'b1;
      ifc.collect_data = 1'b0;
      exp_q.delete();
      tick();
      chk("mr_rq", {31'b0, ifc.read_request}, 32'd0);
      chk("mr_valid", {31'b0, ifc.fx3_data_valid}, 32'd0);
      chk("mr_pe", {31'b0, ifc.fx3_packet_end}, 32'd0);
      chk("mr_bursts", {16'b0, ifc.burst_count}, 32'd0);
      chk("mr_proto", {31'b0, ifc.protocol_error}, 32'd0);
      rst = 1'b0;
      repeat (20) tick();
      chk("mr_rises", rises, 5);
      chk("mr_rq_idle", {31'b0, ifc.read_request}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
